// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   XLEN / INSTR_WIDTH : address and instruction widths
//   FETCH_ENTRY_W      : width of one {pc, instr} queue entry
//   fetch_entry_t      : packed queue payload
package ifetch_queue_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned INSTR_WIDTH   = 32;
    localparam int unsigned FETCH_ENTRY_W = XLEN + INSTR_WIDTH;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Word-align a PC; the low two bits are silently dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request and
// decode handshake.
//   master : the fetch queue (drives imem_pc and the decode head)
//   slave  : the surrounding core (memory, decode, redirect source)
interface ifetch_queue_if;
    import ifetch_queue_pkg::*;

    logic [XLEN-1:0]        imem_pc;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [XLEN-1:0]        dec_pc;
    logic [INSTR_WIDTH-1:0] dec_instr;

    modport master (
        output imem_pc, dec_valid, dec_pc, dec_instr,
        input  imem_instr, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_pc, dec_valid, dec_pc, dec_instr,
        output imem_instr, redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
//   push_i/wdata_i : write one entry at the tail
//   pop_i          : retire the head entry
//   flush_i        : drop all entries (overrides push and pop)
//   rdata_o        : head entry (combinational read of storage)
//   count_o        : current occupancy, 0..DEPTH
module ifetch_queue_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer/count next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && !flush_i && count_q == '0));

endmodule

// File: rtl/ifetch_queue.sv
// Front-end fetch stage: owns the PC, reads instruction memory
// combinationally, queues {pc, instr} pairs and hands them to decode.
//   clk, rst_n : clock and synchronous active-low reset
//   fetch_en   : allow pushes / PC advance
//   bus        : imem port, redirect request, decode valid/ready head
//   q_count    : queue occupancy
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    ifetch_queue_if.master          bus,
    output logic [$clog2(QDEPTH):0] q_count
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            push_c;
    logic            pop_c;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head_entry;

    // Redirect suppresses both sides; a full queue may still push when popping.
    assign pop_c  = bus.dec_valid & bus.dec_ready;
    assign push_c = fetch_en & ~bus.redirect_valid
                  & ((q_count < CNT_W'(QDEPTH)) | pop_c);

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = align_pc(bus.redirect_pc);
        else if (push_c)        pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = bus.imem_instr;

    ifetch_queue_fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (bus.redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .count_o (q_count)
    );

    assign bus.imem_pc   = pc_q;
    assign bus.dec_valid = (q_count != '0) & ~bus.redirect_valid;
    assign bus.dec_pc    = head_entry.pc;
    assign bus.dec_instr = head_entry.instr;

    a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fill, steady stream, redirect/flush,
// back-to-back redirects, mid-stream reset, and PC wrap at the top of memory.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_en;
    logic       fetch_en_w;
    logic [2:0] q_count;
    logic [2:0] q_count_w;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_queue_if bus ();
    ifetch_queue_if bus_w ();

    // Instruction memory model: instruction is a function of its address.
    assign bus.imem_instr   = bus.imem_pc ^ IMASK;
    assign bus_w.imem_instr = bus_w.imem_pc ^ IMASK;

    ifetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_en (fetch_en),
        .bus      (bus),
        .q_count  (q_count)
    );

    ifetch_queue #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_en (fetch_en_w),
        .bus      (bus_w),
        .q_count  (q_count_w)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w [4];
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        exp_w[3] = 32'h0000_0004;

        rst_n              = 1'b0;
        fetch_en           = 1'b0;
        fetch_en_w         = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus_w.dec_ready      = 1'b0;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
        tick();
        tick();

        check_eq("rst_q_count", 32'(q_count), 32'd0);
        check_eq("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check_eq("rst_imem_pc", bus.imem_pc, 32'h0);
        check_eq("rst_imem_pc_w", bus_w.imem_pc, 32'hFFFF_FFF8);
        check_eq("rst_q_count_w", 32'(q_count_w), 32'd0);

        // Fill with decode stalled.
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        #1;
        check_eq("fill_empty_valid", 32'(bus.dec_valid), 32'd0);
        tick();
        check_eq("fill_cnt1", 32'(q_count), 32'd1);
        check_eq("fill_valid1", 32'(bus.dec_valid), 32'd1);
        tick();
        tick();
        tick();
        check_eq("fill_cnt4", 32'(q_count), 32'd4);
        check_eq("fill_imem_pc", bus.imem_pc, 32'h10);
        tick();
        check_eq("full_cnt_hold", 32'(q_count), 32'd4);
        check_eq("full_imem_pc_hold", bus.imem_pc, 32'h10);
        check_eq("full_head_pc", bus.dec_pc, 32'h0);
        check_eq("full_head_instr", bus.dec_instr, 32'hA5A5_0000);

        // Full queue streaming: one pop and one push per cycle.
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("stream_valid", 32'(bus.dec_valid), 32'd1);
            check_eq("stream_pc", bus.dec_pc, 32'(4 * i));
            check_eq("stream_instr", bus.dec_instr, 32'(4 * i) ^ IMASK);
            tick();
            check_eq("stream_cnt", 32'(q_count), 32'd4);
        end
        check_eq("stream_imem_pc", bus.imem_pc, 32'h30);

        // Drain one to reach count 3, then redirect with a pop attempt.
        fetch_en = 1'b0;
        tick();
        check_eq("pre_redir_cnt", 32'(q_count), 32'd3);
        check_eq("pre_redir_head", bus.dec_pc, 32'h24);
        fetch_en           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        #1;
        check_eq("redir_dec_valid", 32'(bus.dec_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("redir_cnt", 32'(q_count), 32'd0);
        check_eq("redir_imem_pc", bus.imem_pc, 32'h100);
        check_eq("redir_bubble", 32'(bus.dec_valid), 32'd0);
        tick();
        check_eq("redir_target_valid", 32'(bus.dec_valid), 32'd1);
        check_eq("redir_target_pc", bus.dec_pc, 32'h100);
        check_eq("redir_target_instr", bus.dec_instr, 32'hA5A5_0100);
        tick();
        check_eq("redir_next_pc", bus.dec_pc, 32'h104);
        check_eq("redir_next_cnt", 32'(q_count), 32'd1);

        // Refill to full, then redirect with pop attempt; then back-to-back redirects.
        bus.dec_ready = 1'b0;
        tick();
        tick();
        tick();
        check_eq("refill_cnt", 32'(q_count), 32'd4);
        check_eq("refill_imem_pc", bus.imem_pc, 32'h114);
        bus.dec_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        #1;
        check_eq("full_redir_valid", 32'(bus.dec_valid), 32'd0);
        tick();
        check_eq("b2b_cnt1", 32'(q_count), 32'd0);
        check_eq("b2b_imem_pc1", bus.imem_pc, 32'h200);
        bus.redirect_pc = 32'h0000_0300;
        tick();
        bus.redirect_valid = 1'b0;
        bus.dec_ready      = 1'b0;
        #1;
        check_eq("b2b_cnt2", 32'(q_count), 32'd0);
        check_eq("b2b_imem_pc2", bus.imem_pc, 32'h300);
        tick();
        check_eq("b2b_head_pc", bus.dec_pc, 32'h300);
        tick();
        tick();
        check_eq("b2b_cnt3", 32'(q_count), 32'd3);
        check_eq("b2b_head_hold", bus.dec_pc, 32'h300);
        check_eq("b2b_head_instr", bus.dec_instr, 32'hA5A5_0300);

        // Mid-stream reset with count 2 and a pending pop/push.
        bus.dec_ready = 1'b1;
        fetch_en      = 1'b0;
        tick();
        check_eq("mid_cnt2", 32'(q_count), 32'd2);
        check_eq("mid_head", bus.dec_pc, 32'h304);
        rst_n    = 1'b0;
        fetch_en = 1'b1;
        tick();
        rst_n    = 1'b1;
        fetch_en = 1'b0;
        #1;
        check_eq("mid_rst_cnt", 32'(q_count), 32'd0);
        check_eq("mid_rst_valid", 32'(bus.dec_valid), 32'd0);
        check_eq("mid_rst_pc", bus.imem_pc, 32'h0);
        tick();
        tick();
        check_eq("hold_pc", bus.imem_pc, 32'h0);
        check_eq("hold_cnt", 32'(q_count), 32'd0);
        fetch_en = 1'b1;
        tick();
        check_eq("resume_cnt", 32'(q_count), 32'd1);
        check_eq("resume_pc", bus.dec_pc, 32'h0);
        check_eq("resume_instr", bus.dec_instr, 32'hA5A5_0000);
        tick();
        check_eq("resume_next_pc", bus.dec_pc, 32'h4);

        // PC wraps past the top of the address space.
        check_eq("wrap_rst_pc", bus_w.imem_pc, 32'hFFFF_FFF8);
        fetch_en_w      = 1'b1;
        bus_w.dec_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("wrap_valid", 32'(bus_w.dec_valid), 32'd1);
            check_eq("wrap_pc", bus_w.dec_pc, exp_w[i]);
            check_eq("wrap_instr", bus_w.dec_instr, exp_w[i] ^ IMASK);
            tick();
        end
        check_eq("wrap_imem_pc", bus_w.imem_pc, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
